// File: rtl/fpu_lzd_arbiter_pkg.sv
// Shared FPU constants for the leading-zero detector and its arbiter.
// Contents: LZD operand/count widths and the requester ids that tag each
// result so the exponent-adjust logic knows which front end it belongs to.
package fpu_lzd_arbiter_pkg;

  localparam int LZD_W     = 32;
  localparam int LZD_CNT_W = 6;

  // Requester ids carried alongside each operand through the pipeline.
  localparam logic REQ_ADDSUB = 1'b0;
  localparam logic REQ_I2F    = 1'b1;

endpackage

// File: rtl/fpu_lzd_arbiter_if.sv
// Handshake bundle between the normalization front ends and the LZD arbiter.
// master: requesters + result consumer (drive valids/data/flush/resp_ready).
// slave : the arbiter (drives readys and the tagged result).
interface fpu_lzd_arbiter_if;
  import fpu_lzd_arbiter_pkg::*;

  logic                 flush;
  logic                 req0_valid;
  logic                 req0_ready;
  logic [LZD_W-1:0]     req0_data;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [LZD_W-1:0]     req1_data;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_id;
  logic [LZD_CNT_W-1:0] resp_count;
  logic                 resp_zero;

  modport master (
    output flush, req0_valid, req0_data, req1_valid, req1_data, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_count, resp_zero
  );

  modport slave (
    input  flush, req0_valid, req0_data, req1_valid, req1_data, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_count, resp_zero
  );

endinterface

// File: rtl/fpu_lzd_arbiter_lzd32.sv
// fpu_lzd32: combinational 32-bit leading-zero detector built as a tree of
// 2-bit leaves. Latency: zero cycles (pure combinational). No handshake.
// Ports: data (operand), count (zeros from bit 31, 0..32), zero (data == 0).
module fpu_lzd32
  import fpu_lzd_arbiter_pkg::*;
(
  input  logic [LZD_W-1:0]     data,
  output logic [LZD_CNT_W-1:0] count,
  output logic                 zero
);

  always_comb begin : tree
    // Level l holds 16>>l nodes, each covering 2^(l+1) bits; node 2i+1 is
    // the more significant half of its parent i.
    logic       z [0:4][0:15];
    logic [4:0] c [0:4][0:15];

    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 16; i++) begin
        z[l][i] = 1'b0;
        c[l][i] = '0;
      end
    end

    for (int i = 0; i < 16; i++) begin
      z[0][i] = !(data[2*i+1] || data[2*i]);
      c[0][i] = {4'b0, !data[2*i+1]};
    end

    // If the upper half is all zero, the count is the lower half's count
    // plus the upper half's width (2^l); otherwise the upper count stands.
    for (int l = 1; l < 5; l++) begin
      for (int i = 0; i < (16 >> l); i++) begin
        z[l][i] = z[l-1][2*i+1] && z[l-1][2*i];
        c[l][i] = z[l-1][2*i+1] ? (c[l-1][2*i] | (5'd1 << l)) : c[l-1][2*i+1];
      end
    end

    zero  = z[4][0];
    // The tree saturates at 31 for an all-zero word; 32 is substituted here.
    count = z[4][0] ? 6'd32 : {1'b0, c[4][0]};
  end

endmodule

// File: rtl/fpu_lzd_arbiter.sv
// Shares one LZD between the add/sub normalizer (req0) and the int-to-bf16
// converter (req1) with round-robin arbitration and a tagged result.
// Latency: result valid two cycles after the accepting cycle; one per cycle.
// Backpressure: resp_ready low holds S2, then S1; readys drop once S1 is held.
// Ports: clk, rst (async, active-high), bus (slave modport: flush, two
// request handshakes, one tagged response handshake).
module fpu_lzd_arbiter
  import fpu_lzd_arbiter_pkg::*;
#(
  parameter int WIDTH = LZD_W,
  parameter int CNT_W = LZD_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  fpu_lzd_arbiter_if.slave bus
);

  logic             rr_ptr;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_id;

  logic             s2_valid;
  logic [CNT_W-1:0] s2_count;
  logic             s2_zero;
  logic             s2_id;

  logic             s2_free;
  logic             s1_free;
  logic             grant0;
  logic             grant1;
  logic             rdy0;
  logic             rdy1;
  logic             take;
  logic             take_id;

  logic [CNT_W-1:0] lzd_count;
  logic             lzd_zero;

  always_comb begin
    s2_free = !s2_valid || bus.resp_ready;
    s1_free = !s1_valid || s2_free;
    // A lone requester always wins; on contention rr_ptr picks.
    grant1  = bus.req1_valid && (!bus.req0_valid || rr_ptr);
    grant0  = bus.req0_valid && !grant1;
    // rst gating keeps the readys at their reset value while rst is held,
    // even though they are otherwise combinational.
    rdy0    = grant0 && s1_free && !bus.flush && !rst;
    rdy1    = grant1 && s1_free && !bus.flush && !rst;
    take    = rdy0 || rdy1;
    take_id = rdy1 ? REQ_I2F : REQ_ADDSUB;
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;

  // Stage 1: accepted operand and its owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= 1'b0;
    end else begin
      if (bus.flush) begin
        s1_valid <= 1'b0;
      end else if (s1_free) begin
        s1_valid <= take;
      end
      if (take) begin
        s1_data <= rdy1 ? bus.req1_data : bus.req0_data;
        s1_id   <= take_id;
      end
    end
  end

  fpu_lzd32 u_lzd (
    .data  (s1_data),
    .count (lzd_count),
    .zero  (lzd_zero)
  );

  // Stage 2: result register. Fields only change when S2 is free, so they
  // stay stable for the whole time a response is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_count <= '0;
      s2_zero  <= 1'b0;
      s2_id    <= 1'b0;
    end else begin
      if (bus.flush) begin
        s2_valid <= 1'b0;
      end else if (s2_free) begin
        s2_valid <= s1_valid;
      end
      if (s2_free && s1_valid) begin
        s2_count <= lzd_count;
        s2_zero  <= lzd_zero;
        s2_id    <= s1_id;
      end
    end
  end

  // Loser of the last accepted handshake gets priority next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (take) begin
      rr_ptr <= ~take_id;
    end
  end

  assign bus.resp_valid = s2_valid;
  assign bus.resp_id    = s2_id;
  assign bus.resp_count = s2_count;
  assign bus.resp_zero  = s2_zero;

endmodule
